xcom_cmd_arb: RTL

- Command arbiter in front of the XCOM transmit core, in the c_clk domain.
- Two requesters share the core: the tProc command port and the PS command port. The PS side comes from AXI register writes and is already synchronized to c_clk.
- Each source is buffered in a small FIFO. Sources are granted by priority with a starvation guard. One command at a time is presented to the core over a valid/ready handshake.
- Sync-class opcodes are held until the next pulse-sync rising edge.

---
 rtl/xcom_cmd_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/xcom_cmd_arb.sv
// Command arbiter for the XCOM transmit core. Two per-source FIFOs (tProc, PS) are arbitrated
// with tProc priority and a PS starvation guard. One command is presented at a time on valid/ready.
module xcom_cmd_arb #(
  parameter int unsigned QAW        = 2,
  parameter int unsigned MAX_WAIT   = 3,
  parameter int unsigned SYNC_ALIGN = 1,
  parameter logic [4:0]  SYNC_OP    = 5'd8
) (
  input  logic           c_clk,
  input  logic           c_rst,
  input  logic           tp_en_i,
  input  logic [4:0]     tp_op_i,
  input  logic [31:0]    tp_dt1_i,
  input  logic [31:0]    tp_dt2_i,
  output logic           tp_rdy_o,
  input  logic           ps_en_i,
  input  logic [4:0]     ps_op_i,
  input  logic [31:0]    ps_dt1_i,
  input  logic [31:0]    ps_dt2_i,
  output logic           ps_rdy_o,
  input  logic           sync_i,
  output logic           cmd_vld_o,
  output logic           cmd_src_o,
  output logic [4:0]     cmd_op_o,
  output logic [31:0]    cmd_dt1_o,
  output logic [31:0]    cmd_dt2_o,
  input  logic           cmd_rdy_i,
  input  logic           err_clr_i,
  output logic           tp_ovf_o,
  output logic           ps_ovf_o,
  output logic [QAW:0]   tp_lvl_o,
  output logic [QAW:0]   ps_lvl_o
);

  localparam int unsigned DEPTH    = 1 << QAW;
  localparam logic [QAW:0] FULL_LVL = (QAW+1)'(DEPTH);
  localparam int unsigned WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MW     = WW'(MAX_WAIT);

  typedef logic [68:0] entry_t;
  typedef enum logic [1:0] {S_IDLE, S_WSYNC, S_ISSUE} state_t;

  entry_t          r_tp_mem [0:DEPTH-1];
  entry_t          r_ps_mem [0:DEPTH-1];
  logic [QAW-1:0]  r_tp_wp, r_tp_rp, r_ps_wp, r_ps_rp;
  logic [QAW:0]    r_tp_cnt, r_ps_cnt;
  logic            r_tp_ovf, r_ps_ovf;
  logic [WW-1:0]   r_ps_wait;
  logic            r_sync_d;
  state_t          r_state, w_state_nxt;
  logic            r_src;
  logic [4:0]      r_op;
  logic [31:0]     r_dt1, r_dt2;

  logic            w_tp_full, w_tp_empty, w_ps_full, w_ps_empty;
  logic            w_tp_push, w_ps_push, w_tp_pop, w_ps_pop;
  logic            w_grant, w_grant_ps;
  entry_t          w_head;

  assign w_tp_full  = (r_tp_cnt == FULL_LVL);
  assign w_ps_full  = (r_ps_cnt == FULL_LVL);
  assign w_tp_empty = (r_tp_cnt == '0);
  assign w_ps_empty = (r_ps_cnt == '0);
  // Acceptance depends only on registered occupancy, never on a same-cycle pop.
  assign w_tp_push  = tp_en_i & ~w_tp_full;
  assign w_ps_push  = ps_en_i & ~w_ps_full;

  always_ff @(posedge c_clk) begin
    if (w_tp_push) r_tp_mem[r_tp_wp] <= {tp_op_i, tp_dt1_i, tp_dt2_i};
    if (w_ps_push) r_ps_mem[r_ps_wp] <= {ps_op_i, ps_dt1_i, ps_dt2_i};
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_tp_wp  <= '0;
      r_tp_rp  <= '0;
      r_tp_cnt <= '0;
      r_tp_ovf <= 1'b0;
      r_ps_wp  <= '0;
      r_ps_rp  <= '0;
      r_ps_cnt <= '0;
      r_ps_ovf <= 1'b0;
    end else begin
      if (w_tp_push) r_tp_wp <= r_tp_wp + 1'b1;
      if (w_tp_pop)  r_tp_rp <= r_tp_rp + 1'b1;
      if (w_tp_push & ~w_tp_pop)      r_tp_cnt <= r_tp_cnt + 1'b1;
      else if (~w_tp_push & w_tp_pop) r_tp_cnt <= r_tp_cnt - 1'b1;
      if (tp_en_i & w_tp_full) r_tp_ovf <= 1'b1;
      else if (err_clr_i)      r_tp_ovf <= 1'b0;

      if (w_ps_push) r_ps_wp <= r_ps_wp + 1'b1;
      if (w_ps_pop)  r_ps_rp <= r_ps_rp + 1'b1;
      if (w_ps_push & ~w_ps_pop)      r_ps_cnt <= r_ps_cnt + 1'b1;
      else if (~w_ps_push & w_ps_pop) r_ps_cnt <= r_ps_cnt - 1'b1;
      if (ps_en_i & w_ps_full) r_ps_ovf <= 1'b1;
      else if (err_clr_i)      r_ps_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_ps  = 1'b0;
    w_tp_pop    = 1'b0;
    w_ps_pop    = 1'b0;
    w_head      = r_tp_mem[r_tp_rp];
    case (r_state)
      S_IDLE: begin
        if (!w_tp_empty || !w_ps_empty) begin
          w_grant = 1'b1;
          if (w_tp_empty)      w_grant_ps = 1'b1;
          else if (w_ps_empty) w_grant_ps = 1'b0;
          else                 w_grant_ps = (r_ps_wait >= MW);
          w_tp_pop = ~w_grant_ps;
          w_ps_pop = w_grant_ps;
          w_head   = w_grant_ps ? r_ps_mem[r_ps_rp] : r_tp_mem[r_tp_rp];
          if ((SYNC_ALIGN != 0) && (w_head[68:64] == SYNC_OP)) w_state_nxt = S_WSYNC;
          else                                                 w_state_nxt = S_ISSUE;
        end
      end
      S_WSYNC: if (sync_i && !r_sync_d) w_state_nxt = S_ISSUE;
      S_ISSUE: if (cmd_rdy_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_state   <= S_IDLE;
      r_src     <= 1'b0;
      r_op      <= '0;
      r_dt1     <= '0;
      r_dt2     <= '0;
      r_ps_wait <= '0;
      r_sync_d  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sync_d <= sync_i;
      if (w_grant) begin
        r_src <= w_grant_ps;
        r_op  <= w_head[68:64];
        r_dt1 <= w_head[63:32];
        r_dt2 <= w_head[31:0];
      end
      // Starvation counter tracks tProc wins only while PS is actually waiting.
      if (w_ps_empty || (w_grant && w_grant_ps)) r_ps_wait <= '0;
      else if (w_grant && r_ps_wait != MW)       r_ps_wait <= r_ps_wait + 1'b1;
    end
  end

  assign cmd_vld_o = (r_state == S_ISSUE);
  assign cmd_src_o = r_src;
  assign cmd_op_o  = r_op;
  assign cmd_dt1_o = r_dt1;
  assign cmd_dt2_o = r_dt2;
  assign tp_rdy_o  = ~w_tp_full;
  assign ps_rdy_o  = ~w_ps_full;
  assign tp_ovf_o  = r_tp_ovf;
  assign ps_ovf_o  = r_ps_ovf;
  assign tp_lvl_o  = r_tp_cnt;
  assign ps_lvl_o  = r_ps_cnt;

endmodule
